// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, tx feeder FSM states
// and start-pulse width.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int TX_EN_PULSE_W = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    GAP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read.
// Ports: wr_en/wr_data push, rd_en pop, rd_data head, full/empty/count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_d;
  logic             wr_acc;
  logic             rd_acc;

  // A full FIFO drops the push even if a pop shares the edge.
  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_d = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them into uart_tx one frame at a time.
// Ports: wr_* push side, full/empty/count/overflow status, uart_tx_* link, idle.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   uart_tx_en,
  output logic [UART_DATA_W-1:0] uart_tx_data,
  input  logic                   uart_tx_busy,
  input  logic                   uart_tx_done,
  output logic                   idle
);

  localparam logic [15:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  tx_state_e              state_q;
  tx_state_e              state_d;
  logic [15:0]            gap_q;
  logic [15:0]            gap_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !uart_tx_busy) begin
          state_d = LOAD;
          pop     = 1'b1;
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        if (uart_tx_done) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      overflow     <= 1'b0;
      idle         <= 1'b1;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      uart_tx_en <= (state_d == LOAD);
      if (pop) uart_tx_data <= head;
      if (wr_en && full) overflow <= 1'b1;
      // Staying in IDLE means no pop, so only a push can fill it.
      idle <= (state_q == IDLE) && (state_d == IDLE)
           && empty && !wr_en;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: u0 with no gap, u5 with a 5-cycle gap.
// Stimulus queues expected {byte, cycle}; a monitor checks every start pulse.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       wr0 = 0, busy0 = 0, done0 = 0;
  logic [7:0] wd0 = 0;
  logic       full0, empty0, ovf0, en0, idle0;
  logic [4:0] cnt0;
  logic [7:0] data0;

  logic       wr5 = 0, busy5 = 0, done5 = 0;
  logic [7:0] wd5 = 0;
  logic       full5, empty5, ovf5, en5, idle5;
  logic [4:0] cnt5;
  logic [7:0] data5;

  uart_tx_feeder #(.DEPTH(16), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr0), .wr_data(wd0),
    .full(full0), .empty(empty0), .count(cnt0),
    .overflow(ovf0), .uart_tx_en(en0), .uart_tx_data(data0),
    .uart_tx_busy(busy0), .uart_tx_done(done0), .idle(idle0)
  );

  uart_tx_feeder #(.DEPTH(16), .GAP_CYCLES(5)) u5 (
    .clk(clk), .rst(rst), .wr_en(wr5), .wr_data(wd5),
    .full(full5), .empty(empty5), .count(cnt5),
    .overflow(ovf5), .uart_tx_en(en5), .uart_tx_data(data5),
    .uart_tx_busy(busy5), .uart_tx_done(done5), .idle(idle5)
  );

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q0[$];
  exp_t q5[$];
  exp_t e0, e5;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && en0) begin
      chk("busy_guard0", busy0, 0);
      if (q0.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_en0: got byte %0h, none expected (cycle %0d)",
                 data0, cyc);
      end else begin
        e0 = q0.pop_front();
        chk("tx_data0", data0, e0.data);
        chk("tx_cycle0", cyc, e0.at);
      end
    end
    if (!rst && en5) begin
      chk("busy_guard5", busy5, 0);
      if (q5.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_en5: got byte %0h, none expected (cycle %0d)",
                 data5, cyc);
      end else begin
        e5 = q5.pop_front();
        chk("tx_data5", data5, e5.data);
        chk("tx_cycle5", cyc, e5.at);
      end
    end
  end

  task automatic pulse_done0(input int c);
    go(c);
    done0 = 1;
    go(c + 1);
    done0 = 0;
  endtask

  initial begin
    int t;

    // reset state
    go(2);
    @(negedge clk);
    chk("rst_count", cnt0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_en", en0, 0);
    chk("rst_data", data0, 8'h00);
    chk("rst_idle", idle0, 1);
    go(3);
    rst = 0;

    // single byte
    t = 5;
    go(t);
    wr0 = 1;
    wd0 = 8'hA5;
    q0.push_back('{8'hA5, t + 2});
    go(t + 1);
    wr0 = 0;
    @(negedge clk);
    chk("sb_count1", cnt0, 1);
    chk("sb_empty1", empty0, 0);
    chk("sb_idle1", idle0, 0);
    go(t + 2);
    @(negedge clk);
    chk("sb_count2", cnt0, 0);
    go(t + 50);
    done0 = 1;
    @(negedge clk);
    chk("sb_data_hold", data0, 8'hA5);
    go(t + 51);
    done0 = 0;
    @(negedge clk);
    chk("sb_idle51", idle0, 0);
    go(t + 52);
    @(negedge clk);
    chk("sb_idle52", idle0, 1);

    // burst 01..10
    t = 60;
    for (int i = 0; i < 16; i++) begin
      go(t + i);
      wr0 = 1;
      wd0 = 8'(i + 1);
      q0.push_back('{8'(i + 1), (i == 0) ? t + 2 : t + 10 * i + 12});
    end
    go(t + 16);
    wr0 = 0;
    @(negedge clk);
    chk("burst_count", cnt0, 15);
    chk("burst_full", full0, 0);
    chk("burst_ovf", ovf0, 0);
    for (int k = 1; k <= 16; k++) pulse_done0(t + 10 * k + 10);
    go(t + 172);
    @(negedge clk);
    chk("burst_idle", idle0, 1);
    chk("burst_count_end", cnt0, 0);

    // overflow with FSM parked in WAIT
    t = 240;
    go(t);
    wr0 = 1;
    wd0 = 8'h80;
    q0.push_back('{8'h80, t + 2});
    go(t + 1);
    wr0 = 0;
    for (int j = 1; j <= 17; j++) begin
      go(t + 3 + j);
      wr0 = 1;
      wd0 = 8'(8'h40 + j);
      if (j <= 13) q0.push_back('{8'(8'h40 + j), t + 22 + 10 * j});
      if (j == 17) begin
        @(negedge clk);
        chk("ovf_count16", cnt0, 16);
        chk("ovf_full", full0, 1);
        chk("ovf_pre", ovf0, 0);
      end
    end
    go(t + 21);
    wr0 = 0;
    @(negedge clk);
    chk("ovf_set", ovf0, 1);
    chk("ovf_count_held", cnt0, 16);
    for (int j = 0; j <= 12; j++) pulse_done0(t + 30 + 10 * j);
    go(t + 155);
    @(negedge clk);
    chk("mid_count3", cnt0, 3);
    chk("ovf_sticky", ovf0, 1);

    // reset in WAIT with 3 queued
    go(t + 156);
    rst = 1;
    @(negedge clk);
    chk("mrst_count", cnt0, 0);
    chk("mrst_idle", idle0, 1);
    chk("mrst_en", en0, 0);
    chk("mrst_ovf", ovf0, 0);
    go(t + 157);
    rst = 0;
    pulse_done0(t + 160);
    go(t + 163);
    @(negedge clk);
    chk("mrst_en_after", en0, 0);
    chk("mrst_idle_after", idle0, 1);

    // busy interlock
    t = 410;
    go(t);
    busy0 = 1;
    wr0 = 1;
    wd0 = 8'h3C;
    go(t + 1);
    wr0 = 0;
    go(t + 5);
    @(negedge clk);
    chk("busy_count", cnt0, 1);
    chk("busy_en", en0, 0);
    go(t + 10);
    busy0 = 0;
    q0.push_back('{8'h3C, t + 11});
    go(t + 11);
    @(negedge clk);
    chk("busy_pop", cnt0, 0);
    pulse_done0(t + 30);
    go(t + 33);
    @(negedge clk);
    chk("busy_idle", idle0, 1);

    // gap of 5 on u5
    t = 450;
    go(t);
    wr5 = 1;
    wd5 = 8'hAA;
    q5.push_back('{8'hAA, t + 2});
    go(t + 1);
    wd5 = 8'hBB;
    q5.push_back('{8'hBB, t + 17});
    go(t + 2);
    wr5 = 0;
    go(t + 10);
    done5 = 1;
    go(t + 11);
    done5 = 0;
    go(t + 16);
    @(negedge clk);
    chk("gap_count", cnt5, 1);
    go(t + 25);
    done5 = 1;
    go(t + 26);
    done5 = 0;
    go(t + 31);
    @(negedge clk);
    chk("gap_idle31", idle5, 0);
    go(t + 32);
    @(negedge clk);
    chk("gap_idle32", idle5, 1);

    go(t + 40);
    @(negedge clk);
    chk("sb0_drained", q0.size(), 0);
    chk("sb5_drained", q5.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
